// File: rtl/exp_request_gen_pkg.sv
// rtl/exp_request_gen_pkg.sv - shared types and constants for exp_request_gen
// Purpose: FSM state encoding, source count, debounce defaults and small
//          bit-vector helpers used by the exception request generator.
// Ports:   none (package).
package exp_request_gen_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      SERV = 2'd2
   } state_t;

   localparam int NUM_SRC      = 3;
   localparam int DEF_DB_LIMIT = 1000000;
   localparam int DEF_DB_W     = 20;

   // Index of the lowest set bit; source 0 has the highest priority.
   function automatic logic [1:0] lowest_set(input logic [NUM_SRC-1:0] v);
      lowest_set = 2'd0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (v[i]) lowest_set = 2'(i);
      end
   endfunction

   function automatic logic [1:0] count_ones(input logic [NUM_SRC-1:0] v);
      count_ones = {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
   endfunction

endpackage

// File: rtl/exp_request_gen_btn_debounce.sv
// rtl/exp_request_gen_btn_debounce.sv - one-bit synchroniser, debouncer and rising-edge detector
// Purpose: brings one raw button into the clock domain, filters it so that only
//          a level held for DB_LIMIT consecutive samples is accepted, and emits a
//          registered one-cycle pulse when the accepted level goes high.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-low reset
//   btn  - raw asynchronous button
//   rise - one-cycle pulse on a debounced 0->1 transition
module btn_debounce
   import exp_request_gen_pkg::*;
#(
   parameter int DB_LIMIT = DEF_DB_LIMIT,
   parameter int DB_W     = DEF_DB_W
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic rise
);

   localparam logic [DB_W-1:0] LIMIT_M1 = DB_W'(DB_LIMIT - 1);

   logic            sync1;
   logic            sync2;
   logic            stable;
   logic            stable_d;
   logic [DB_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1    <= 1'b0;
         sync2    <= 1'b0;
         stable   <= 1'b0;
         stable_d <= 1'b0;
         cnt      <= '0;
         rise     <= 1'b0;
      end else begin
         sync1    <= btn;
         sync2    <= sync1;
         stable_d <= stable;
         // Registered edge: adds one cycle between the stable flip and the pulse.
         rise     <= stable & ~stable_d;
         if (sync2 == stable) begin
            cnt <= '0;
         end else if (cnt == LIMIT_M1) begin
            // DB_LIMIT-th consecutive disagreeing sample: accept the new level.
            stable <= sync2;
            cnt    <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/exp_request_gen.sv
// rtl/exp_request_gen.sv - button-driven exception request generator for the CPU exception inputs
// Purpose: debounces three buttons, latches their rising edges as pending
//          requests, presents one request at a time to the CPU in fixed
//          priority order and retires it through the CP0 handshake.
// Ports:
//   clk        - system clock
//   rst        - synchronous active-low reset
//   btn[2:0]   - raw buttons, bit i is source i
//   hasExp     - CP0 exception-accepted pulse
//   isEret     - CP0 ERET-executed pulse
//   expSrc0..2 - held request to the CPU, source 0 highest priority
//   pending    - latched edges not yet accepted
//   busy       - high while a request is presented or being serviced
//   drop_count - saturating count of edges coalesced into an existing pending bit
module exp_request_gen
   import exp_request_gen_pkg::*;
#(
   parameter int DB_LIMIT = DEF_DB_LIMIT,
   parameter int DB_W     = DEF_DB_W
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] btn,
   input  logic       hasExp,
   input  logic       isEret,
   output logic       expSrc0,
   output logic       expSrc1,
   output logic       expSrc2,
   output logic [2:0] pending,
   output logic       busy,
   output logic [7:0] drop_count
);

   logic [NUM_SRC-1:0] rise;
   logic [NUM_SRC-1:0] clr;
   logic [NUM_SRC-1:0] drops;
   logic [NUM_SRC-1:0] req;
   logic [1:0]         sel;
   logic [1:0]         first_idx;
   logic [1:0]         ndrop;
   logic [8:0]         drop_sum;
   state_t             state;

   genvar g;
   generate
      for (g = 0; g < NUM_SRC; g++) begin : g_db
         btn_debounce #(
            .DB_LIMIT (DB_LIMIT),
            .DB_W     (DB_W)
         ) u_db (
            .clk  (clk),
            .rst  (rst),
            .btn  (btn[g]),
            .rise (rise[g])
         );
      end
   endgenerate

   // clr only fires in the cycle the CPU accepts the presented channel.
   always_comb begin
      clr = '0;
      if (state == REQ && hasExp) clr[sel] = 1'b1;
   end

   // An edge arriving while the same channel is still pending (and not being
   // accepted this cycle) carries no new information and is counted as dropped.
   assign drops     = rise & pending & ~clr;
   assign ndrop     = count_ones(drops);
   assign drop_sum  = {1'b0, drop_count} + {7'd0, ndrop};
   assign first_idx = lowest_set(pending);

   always_ff @(posedge clk) begin
      if (!rst) begin
         pending    <= '0;
         drop_count <= '0;
         state      <= IDLE;
         sel        <= 2'd0;
         req        <= '0;
      end else begin
         pending    <= rise | (pending & ~clr);
         drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];

         case (state)
            IDLE: begin
               if (|pending) begin
                  sel   <= first_idx;
                  req   <= 3'b001 << first_idx;
                  state <= REQ;
               end
            end
            REQ: begin
               // hasExp wins over a coincident isEret.
               if (hasExp) begin
                  req   <= '0;
                  state <= SERV;
               end
            end
            SERV: begin
               if (isEret) state <= IDLE;
            end
            default: begin
               req   <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

   assign expSrc0 = req[0];
   assign expSrc1 = req[1];
   assign expSrc2 = req[2];
   assign busy    = (state != IDLE);

endmodule

// File: doc/exp_request_gen.md
Name: exp_request_gen

Overview:
- Initiator side of the CPU's exception-source interface: turns three raw board buttons into clean, held exception requests.
- Requests drive the top-level expSrc0/1/2 inputs of the CPU and are retired by the CP0 handshake (hasExp = accepted, isEret = handler finished).
- Per-channel synchronisation, debounce, rising-edge capture, pending latch, fixed priority and a coalesced-drop counter.
- Sits beside the CPU top; sole driver of expSrc*.

Parameters:
- DB_LIMIT, 1000000, number of consecutive cycles a synchronised input must differ from its stable value before the stable value flips (10 ms at 100 MHz). Must be ≥ 2.
- DB_W, 20, counter width; must satisfy 2^DB_W > DB_LIMIT.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- btn  in  3  raw asynchronous buttons; bit i is source i.
- hasExp  in  1  CP0 exception-accepted pulse.
- isEret  in  1  CP0 ERET-executed pulse.
- expSrc0  out  1  request to CPU, source 0 (highest priority).
- expSrc1  out  1  request to CPU, source 1.
- expSrc2  out  1  request to CPU, source 2 (lowest priority).
- pending  out  3  latched, not-yet-accepted edges.
- busy  out  1  high while in REQ or SERV.
- drop_count  out  8  saturating count of coalesced edges.

Behaviour:
- Reset (rst=0 at a clk edge): all outputs 0; synchronisers, stable values and debounce counters 0; state IDLE; sel=0. Reset mid-request drops every request and pending bit.
- Sync: two flip-flops per bit.
- Debounce, per bit:
  - If sync == stable, cnt <= 0.
  - Otherwise cnt increments. When cnt == DB_LIMIT-1 and the inputs still differ, stable <= sync and cnt <= 0.
  - A glitch shorter than DB_LIMIT cycles never changes stable.
- Edge: rise[i] = stable[i] & ~stable_d[i], a one-cycle pulse. Falling edges are ignored.
- Pending update each cycle, with clr[i] high only in the cycle REQ accepts channel i:
  - pending[i] <= rise[i] | (pending[i] & ~clr[i]).
  - rise[i] in the clr[i] cycle leaves pending[i]=1 and does not count as a drop.
  - rise[i] while pending[i]=1 and clr[i]=0 increments drop_count, saturating at 255.
- FSM states: IDLE, REQ, SERV.
  - IDLE: if pending != 0, sel <= lowest set index and go to REQ. The selected expSrc goes high on that same edge, i.e. one cycle after pending becomes visible.
  - REQ: exactly one expSrc (expSrc[sel]) is held high until hasExp. On hasExp: expSrc cleared, clr[sel] pulsed, go to SERV. isEret in REQ is ignored. hasExp with isEret in the same cycle: hasExp wins, go to SERV.
  - SERV: all expSrc low. Go to IDLE on isEret. hasExp in SERV is ignored.
  - IDLE after ERET: IDLE re-arbitrates in the next cycle, so a lower-priority source that was pending is presented two cycles after isEret at the earliest.
- Latency: raw press to expSrc high = 2 (sync) + DB_LIMIT (debounce) + 1 (edge) + 1 (pending) + 1 (request) cycles.
- busy = (state != IDLE).
- Priority is fixed 0 > 1 > 2 and is only evaluated in IDLE. No pre-emption of a presented request.

Decomposition:
- Shared package holds:
  - FSM state encodings: IDLE=2'd0, REQ=2'd1, SERV=2'd2.
  - Source-count constant NUM_SRC=3.
  - Default DB_LIMIT.
- One sub-module, btn_debounce: one bit, sync + counter + stable + rise output. It is instantiated 3 times.
- Arbitration FSM and drop counter live in the top of the block.

Test Plan (DB_LIMIT=4):
- Reset: hold rst=0 for 3 cycles with btn=3'b111 → all outputs 0. Release → expSrc0 rises exactly 9 cycles later (2+4+1+1+1), expSrc1/2 stay 0.
- Glitch: btn[1] high for 3 cycles, then low → pending stays 0, expSrc1 never asserts, drop_count=0.
- Handshake: press btn[2] → expSrc2 held high until hasExp pulse. Next cycle expSrc2=0, pending=0, busy=1. isEret pulse → busy=0 the following cycle.
- Priority: pending=3'b110 in IDLE → expSrc1 first. After hasExp and isEret, expSrc2 asserts 2 cycles after isEret.
- Coalesce: with channel 0 in SERV, two further debounced presses of btn[0] → pending[0]=1, drop_count=1. A press landing exactly in the hasExp cycle → pending[0]=1, drop_count unchanged.
- Simultaneous hasExp+isEret in REQ → state SERV, expSrc cleared. Apply 255+ drops → drop_count saturates at 8'hFF.
